// File: rtl/spi_arbiter_pkg.sv
// spi_pkg: shared FSM encoding, byte width and default sizing for spi_arbiter.
//   BYTE_W       width of every data byte on the bus
//   DEF_NUM_REQ  default number of requesters
//   DEF_TIMEOUT  default cycles to wait for master completion
//   state_t      arbiter FSM encoding
//   idx_w()      width of a requester index, never below 1 bit
package spi_pkg;

   localparam int BYTE_W      = 8;
   localparam int DEF_NUM_REQ = 4;
   localparam int DEF_TIMEOUT = 64;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_t;

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/spi_arbiter_if.sv
// spi_arbiter_if: requester-side and spi_master-side signals of spi_arbiter.
//   i_req / i_req_data             level requests and one byte per requester
//   o_gnt / o_resp_*               grant, response pulse, received byte, timeout flag
//   o_start_tx / o_tx_data         start pulse and byte towards spi_master
//   i_tx_done / i_rx_data / i_ss   completion, received byte, select from spi_master
//   o_ss_n                         per-slave select fanned out from i_ss
//   o_busy                         arbiter not idle
// Modport master is the arbiter itself; slave is the environment around it.
interface spi_arbiter_if import spi_pkg::*; #(
   parameter int NUM_REQ = DEF_NUM_REQ
);

   logic [NUM_REQ-1:0]        i_req;
   logic [BYTE_W*NUM_REQ-1:0] i_req_data;
   logic [NUM_REQ-1:0]        o_gnt;
   logic [NUM_REQ-1:0]        o_resp_valid;
   logic [BYTE_W-1:0]         o_resp_data;
   logic                      o_resp_err;
   logic                      o_start_tx;
   logic [BYTE_W-1:0]         o_tx_data;
   logic                      i_tx_done;
   logic [BYTE_W-1:0]         i_rx_data;
   logic                      i_ss;
   logic [NUM_REQ-1:0]        o_ss_n;
   logic                      o_busy;

   modport master (
      input  i_req, i_req_data, i_tx_done, i_rx_data, i_ss,
      output o_gnt, o_resp_valid, o_resp_data, o_resp_err, o_start_tx, o_tx_data, o_ss_n, o_busy
   );

   modport slave (
      output i_req, i_req_data, i_tx_done, i_rx_data, i_ss,
      input  o_gnt, o_resp_valid, o_resp_data, o_resp_err, o_start_tx, o_tx_data, o_ss_n, o_busy
   );

endinterface

// File: rtl/spi_arbiter_rr_picker.sv
// rr_picker: combinational round-robin selection.
//   req  request vector
//   ptr  index of the last served requester
//   win  one-hot winner (all-zero when no request)
//   idx  winner index
//   any  at least one request present
module rr_picker #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  win,
   output logic [IW-1:0] idx,
   output logic          any
);

   logic [IW-1:0] j;

   // Offsets are walked from farthest to nearest, so the last hit written is
   // the first set bit at or after ptr+1, wrapping round to ptr itself.
   always_comb begin
      win = '0;
      idx = '0;
      j   = '0;
      for (int i = N; i >= 1; i--) begin
         j = IW'((int'(ptr) + i) % N);
         if (req[j]) begin
            win    = '0;
            win[j] = 1'b1;
            idx    = j;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one spi_master between NUM_REQ requesters, round-robin.
//   i_clk    clock, everything on posedge
//   i_rst_n  synchronous active-low reset
//   bus      spi_arbiter_if.master: requests, grants, responses and master link
// A request in IDLE is granted one edge later with a one-cycle start pulse;
// WAIT holds the grant until i_tx_done or TIMEOUT cycles; RESP emits a one-cycle
// response pulse, then the grant drops and arbitration resumes a cycle later.
module spi_arbiter import spi_pkg::*; #(
   parameter int NUM_REQ = DEF_NUM_REQ,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input logic           i_clk,
   input logic           i_rst_n,
   spi_arbiter_if.master bus
);

   localparam int IW = idx_w(NUM_REQ);
   localparam int CW = $clog2(TIMEOUT) + 1;

   state_t             state, state_n;
   logic [NUM_REQ-1:0] gnt, gnt_n;
   logic [NUM_REQ-1:0] valid, valid_n;
   logic [NUM_REQ-1:0] win;
   logic [IW-1:0]      idx, idx_n;
   logic [IW-1:0]      last, last_n;
   logic [IW-1:0]      win_idx;
   logic [BYTE_W-1:0]  rdata, rdata_n;
   logic [BYTE_W-1:0]  tdata, tdata_n;
   logic               err, err_n;
   logic               start, start_n;
   logic               any;
   logic [CW-1:0]      cnt, cnt_n;

   rr_picker #(.N(NUM_REQ), .IW(IW)) u_pick (
      .req (bus.i_req),
      .ptr (last),
      .win (win),
      .idx (win_idx),
      .any (any)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state <= S_IDLE;
         gnt   <= '0;
         idx   <= '0;
         last  <= IW'(NUM_REQ - 1);
         valid <= '0;
         rdata <= '0;
         err   <= 1'b0;
         start <= 1'b0;
         tdata <= '0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         gnt   <= gnt_n;
         idx   <= idx_n;
         last  <= last_n;
         valid <= valid_n;
         rdata <= rdata_n;
         err   <= err_n;
         start <= start_n;
         tdata <= tdata_n;
         cnt   <= cnt_n;
      end
   end

   always_comb begin
      state_n = state;
      gnt_n   = gnt;
      idx_n   = idx;
      last_n  = last;
      valid_n = '0;
      rdata_n = rdata;
      err_n   = err;
      start_n = 1'b0;
      tdata_n = tdata;
      cnt_n   = cnt;
      case (state)
         S_IDLE: begin
            if (any) begin
               state_n = S_WAIT;
               gnt_n   = win;
               idx_n   = win_idx;
               tdata_n = bus.i_req_data[int'(win_idx)*BYTE_W +: BYTE_W];
               start_n = 1'b1;
               cnt_n   = '0;
            end
         end
         S_WAIT: begin
            cnt_n = cnt + CW'(1);
            // A completion arriving on the timeout cycle still counts as success.
            if (bus.i_tx_done || cnt == CW'(TIMEOUT - 1)) begin
               state_n = S_RESP;
               valid_n = gnt;
               rdata_n = bus.i_tx_done ? bus.i_rx_data : '0;
               err_n   = !bus.i_tx_done;
            end
         end
         S_RESP: begin
            state_n = S_IDLE;
            gnt_n   = '0;
            last_n  = idx;
         end
         default: state_n = S_IDLE;
      endcase
   end

   assign bus.o_gnt        = gnt;
   assign bus.o_resp_valid = valid;
   assign bus.o_resp_data  = rdata;
   assign bus.o_resp_err   = err;
   assign bus.o_start_tx   = start;
   assign bus.o_tx_data    = tdata;
   assign bus.o_ss_n       = ~gnt | {NUM_REQ{bus.i_ss}};
   assign bus.o_busy       = state != S_IDLE;

endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed scoreboard bench for spi_arbiter with a loopback spi_master model.
module tb_spi_arbiter;

   localparam int MST_LAT = 3;

   typedef struct {
      logic [3:0] gnt;
      logic [7:0] txd;
      logic [7:0] data;
      logic       err;
   } exp_t;

   logic clk;
   logic rst_n;
   bit   mst_en;
   int   spur_req;
   int   vectors;
   int   miscompares;
   exp_t sb[$];

   spi_arbiter_if #(.NUM_REQ(4)) bus ();

   spi_arbiter #(.NUM_REQ(4), .TIMEOUT(64)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Serve the transaction at the scoreboard front: grant, hold, response, idle.
   task automatic serve(input bit drop, output int waited);
      exp_t       e;
      int         n;
      bit         seen;
      logic [3:0] ss_exp;
      e = sb[0];
      seen = 0;
      waited = -1;
      for (n = 0; n < 8 && !seen; n++) begin
         @(negedge clk);
         seen = bus.o_start_tx;
      end
      chk("grant_seen", 32'(seen), 1);
      chk("grant_latency", n, 1);
      if (!seen) begin
         void'(sb.pop_front());
         return;
      end
      chk("grant_vec", bus.o_gnt, e.gnt);
      chk("tx_data", bus.o_tx_data, e.txd);
      if (drop) begin
         bus.i_req = '0;
         bus.i_req_data = ~bus.i_req_data;
      end
      seen = 0;
      for (n = 0; n < 200 && !seen; n++) begin
         @(negedge clk);
         seen = |bus.o_resp_valid;
         if (n == 0) chk("start_pulse", bus.o_start_tx, 0);
         if (!seen) begin
            ss_exp = ~e.gnt | {4{bus.i_ss}};
            chk("busy_wait", bus.o_busy, 1);
            chk("tx_hold", bus.o_tx_data, e.txd);
            chk("ss_n", bus.o_ss_n, ss_exp);
         end
      end
      chk("resp_seen", 32'(seen), 1);
      waited = n;
      chk("resp_valid", bus.o_resp_valid, e.gnt);
      chk("resp_data", bus.o_resp_data, e.data);
      chk("resp_err", bus.o_resp_err, e.err);
      void'(sb.pop_front());
      @(negedge clk);
      chk("resp_pulse_end", bus.o_resp_valid, 0);
      chk("gnt_clear", bus.o_gnt, 0);
      chk("busy_after", bus.o_busy, 0);
   endtask

   // spi_master model: loops MOSI back to MISO MST_LAT cycles after start.
   initial begin
      logic [7:0] b;
      int         spur_ack;
      spur_ack = 0;
      bus.i_tx_done = 1'b0;
      bus.i_rx_data = '0;
      bus.i_ss = 1'b1;
      forever begin
         @(negedge clk);
         if (spur_req != spur_ack) begin
            spur_ack++;
            bus.i_rx_data = 8'hEE;
            bus.i_tx_done = 1'b1;
            @(negedge clk);
            bus.i_tx_done = 1'b0;
         end else if (mst_en && bus.o_start_tx) begin
            b = bus.o_tx_data;
            bus.i_ss = 1'b0;
            repeat (MST_LAT) @(negedge clk);
            bus.i_rx_data = b;
            bus.i_tx_done = 1'b1;
            @(negedge clk);
            bus.i_tx_done = 1'b0;
            bus.i_ss = 1'b1;
         end
      end
   end

   initial begin
      int w;
      vectors = 0;
      miscompares = 0;
      rst_n = 1'b0;
      mst_en = 1;
      spur_req = 0;
      bus.i_req = '0;
      bus.i_req_data = '0;
      repeat (2) @(negedge clk);
      chk("rst_gnt", bus.o_gnt, 0);
      chk("rst_resp_valid", bus.o_resp_valid, 0);
      chk("rst_resp_data", bus.o_resp_data, 0);
      chk("rst_resp_err", bus.o_resp_err, 0);
      chk("rst_start", bus.o_start_tx, 0);
      chk("rst_tx_data", bus.o_tx_data, 0);
      chk("rst_busy", bus.o_busy, 0);
      chk("rst_ss_n", bus.o_ss_n, 4'hF);
      rst_n = 1'b1;
      // single requester, loopback, request dropped after grant
      bus.i_req_data = 32'h0000_00A5;
      bus.i_req = 4'b0001;
      sb.push_back('{4'b0001, 8'hA5, 8'hA5, 1'b0});
      serve(1, w);
      chk("done_latency", w, MST_LAT + 1);
      // all requesting: round-robin 0,1,2,3,0
      do_reset();
      bus.i_req_data = 32'h4433_2211;
      bus.i_req = 4'hF;
      for (int k = 0; k < 5; k++)
         sb.push_back('{4'(1 << (k % 4)), 8'((k % 4 + 1) * 17), 8'((k % 4 + 1) * 17), 1'b0});
      for (int k = 0; k < 5; k++) serve(0, w);
      bus.i_req = '0;
      // master never completes: timeout after 64 WAIT cycles
      mst_en = 0;
      bus.i_req_data = 32'h5A00_0000;
      bus.i_req = 4'b1000;
      sb.push_back('{4'b1000, 8'h5A, 8'h00, 1'b1});
      serve(1, w);
      chk("timeout_cycles", w, 64);
      mst_en = 1;
      // requester 1 with select fan-out, then a spurious done in IDLE
      bus.i_req_data = 32'h0000_C300;
      bus.i_req = 4'b0010;
      sb.push_back('{4'b0010, 8'hC3, 8'hC3, 1'b0});
      serve(1, w);
      spur_req++;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("spurious_no_resp", bus.o_resp_valid, 0);
         chk("spurious_idle", bus.o_busy, 0);
      end
      // reset during requester 2 WAIT aborts silently; priority returns to 0
      bus.i_req_data = 32'h0077_0000;
      bus.i_req = 4'b0100;
      @(negedge clk);
      chk("abort_gnt", bus.o_gnt, 4'b0100);
      chk("abort_start", bus.o_start_tx, 1);
      bus.i_req = '0;
      @(negedge clk);
      chk("abort_wait", bus.o_busy, 1);
      rst_n = 1'b0;
      @(negedge clk);
      chk("abort_gnt_clear", bus.o_gnt, 0);
      chk("abort_busy", bus.o_busy, 0);
      chk("abort_ss_n", bus.o_ss_n, 4'hF);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("abort_no_resp", bus.o_resp_valid, 0);
      end
      bus.i_req_data = 32'h4433_2211;
      bus.i_req = 4'hF;
      sb.push_back('{4'b0001, 8'h11, 8'h11, 1'b0});
      serve(1, w);
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4; number of requesters sharing one spi_master.
REQ-002 Parameter TIMEOUT, default 64; max cycles to wait for i_tx_done before abort.
REQ-003 Port i_clk  in  1  single clock; all logic rises on posedge.
REQ-004 Port i_rst_n  in  1  reset, synchronous, active-low.
REQ-005 Port i_req  in  NUM_REQ  per-requester level request.
REQ-006 Port i_req_data  in  8*NUM_REQ  byte per requester; requester k uses bits [8k+7:8k].
REQ-007 Port o_gnt  out  NUM_REQ  one-hot registered grant; all-zero when idle.
REQ-008 Port o_resp_valid  out  NUM_REQ  one-cycle pulse to the served requester.
REQ-009 Port o_resp_data  out  8  received byte, valid with o_resp_valid.
REQ-010 Port o_resp_err  out  1  high with o_resp_valid when the transaction timed out.
REQ-011 Port o_start_tx  out  1  one-cycle start pulse to the master.
REQ-012 Port o_tx_data  out  8  byte to the master, held stable for the whole transaction.
REQ-013 Port i_tx_done  in  1  master completion pulse.
REQ-014 Port i_rx_data  in  8  master received byte, sampled on i_tx_done.
REQ-015 Port i_ss  in  1  master slave-select (active-low).
REQ-016 Port o_ss_n  out  NUM_REQ  per-slave select: o_ss_n[k] = i_ss when o_gnt[k], else 1 (combinational).
REQ-017 Port o_busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, WAIT, RESP; encoding fixed in the package.
REQ-019 IDLE with any i_req high: at the next edge, register o_gnt one-hot on the winner, o_tx_data = winner's byte, o_start_tx = 1, clear the timeout counter, go to WAIT.
REQ-020 Grant latency is 1 cycle: the request is seen at edge t; o_gnt and o_start_tx are visible after edge t.
REQ-021 Round-robin: search starts at index (last_served+1) mod NUM_REQ and wraps to the first set bit; the pointer updates only in RESP.
REQ-022 o_start_tx is high for exactly one cycle per transaction; it returns to 0 at the first WAIT edge.
REQ-023 WAIT: the counter increments each cycle; on i_tx_done, capture i_rx_data into o_resp_data, o_resp_err = 0, go to RESP.
REQ-024 WAIT with counter == TIMEOUT-1 and no i_tx_done: o_resp_data = 0x00, o_resp_err = 1, go to RESP.
REQ-025 i_tx_done and timeout in the same cycle: done wins, err = 0.
REQ-026 RESP lasts one cycle: o_resp_valid[granted] = 1, o_gnt clears, last_served = granted, go to IDLE.
REQ-027 IDLE re-arbitration occurs at the earliest one cycle after RESP; this gap guarantees the master is back in its idle state.
REQ-028 i_req sampled only in IDLE; i_req_data sampled only at grant; later changes are ignored.
REQ-029 Requester dropping i_req mid-transaction: the transaction completes and the response still pulses.
REQ-030 i_tx_done outside WAIT is ignored.
REQ-031 Counter width is clog2(TIMEOUT)+1 bits and does not wrap inside WAIT.

Reset
REQ-032 i_rst_n low at a clock edge: state = IDLE, o_gnt = 0, o_resp_valid = 0, o_resp_data = 0x00, o_resp_err = 0, o_start_tx = 0, o_tx_data = 0x00, counter = 0, last_served = NUM_REQ-1 (so requester 0 has first priority).
REQ-033 Reset mid-transaction aborts with no response pulse; o_ss_n goes all-ones once o_gnt clears.

Structure
REQ-034 Package spi_pkg holds the FSM state localparams, the byte width (8), and default NUM_REQ/TIMEOUT.
REQ-035 One sub-module, rr_picker: combinational; inputs request vector and pointer; outputs one-hot winner and index.
REQ-036 Integrates with spi_master: o_start_tx->i_start_tx, o_tx_data->i_tx_data, o_tx_done->i_tx_done, o_rx_data->i_rx_data, o_ss->i_ss.

Verification
REQ-037 After reset, i_req=0001, data0=0xA5, slave loopback MISO=MOSI -> o_gnt=0001 one cycle later, single o_start_tx, o_resp_valid=0001 with o_resp_data=0xA5, err=0.
REQ-038 i_req=1111 held, bytes 0x11/0x22/0x33/0x44 -> grants in order 0,1,2,3,0; each response matches its byte.
REQ-039 i_tx_done tied low -> after 64 WAIT cycles, o_resp_valid pulses with o_resp_err=1 and o_resp_data=0x00; o_busy=0 the next cycle.
REQ-040 i_rst_n low during WAIT of requester 2 -> no o_resp_valid; next grant goes to requester 0 when all requests are high.
REQ-041 During a requester-1 transaction -> o_ss_n[1] follows i_ss and o_ss_n[0,2,3]=1 throughout; a spurious i_tx_done in IDLE produces no response.
